// File: rtl/spi_frame_master.sv
// SPI master transmitter: sends one 48-bit frame {word0, word1, word2} MSB first
// on sclk/mosi with ss framing, for a receiver that samples on rising sclk.
module spi_frame_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] word0,
  input  logic [15:0] word1,
  input  logic [15:0] word2,
  output logic        sclk,
  output logic        mosi,
  output logic        ss,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [47:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        last_q, last_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;
  logic        done_q, done_d;
  logic        div_end;

  assign div_end = (div_cnt_q == DIV_LAST);

  // NOTE: all state lives in one async-reset register block with non-blocking
  // assignments; the combinational block below only computes the _d values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_end ? 8'd0 : div_cnt_q + 8'd1;
    last_d    = last_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (in_valid) begin
          state_d   = LEAD;
          shift_d   = {word0, word1, word2};
          bit_cnt_d = '0;
          last_d    = 1'b0;
          ss_d      = 1'b1;
          sclk_d    = 1'b0;
          mosi_d    = word0[15];
        end
      end
      LEAD: begin
        if (div_end) begin
          state_d = XFER;
          sclk_d  = 1'b1;
        end
      end
      XFER: begin
        if (div_end) begin
          if (sclk_q) begin
            // Falling edge: present the next bit, or idle-low after bit 0.
            sclk_d  = 1'b0;
            shift_d = shift_q << 1;
            if (bit_cnt_q == 6'd47) begin
              last_d = 1'b1;
              mosi_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
              mosi_d    = shift_q[46];
            end
          end else if (last_q) begin
            state_d = GAP;
            ss_d    = 1'b0;
            done_d  = 1'b1;
            mosi_d  = 1'b0;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (div_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss       = ss_q;
  assign done     = done_q;

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

SPI master transmitter that serialises one 48-bit frame of three signed 16-bit words (word0, word1, word2) onto sclk/mosi/ss. It drives the FPGA's SPI frame receiver, which shifts on rising sclk while ss is high, so this block is the initiating end of the same link. It is used for loopback test and board-to-board forwarding of the three int16 control values.

## Interface
- CLK_DIV, 4, sclk half-period in clk cycles; legal range 1..255.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  frame request; qualifies word0..word2.
- in_ready  output  1  high only in IDLE; a frame is accepted on a clk edge where in_valid && in_ready.
- word0  input  16  first int16, transmitted first, MSB first.
- word1  input  16  second int16.
- word2  input  16  third int16, transmitted last.
- sclk  output  1  SPI clock; idle low; registered.
- mosi  output  1  serial data; changes only while sclk is low; registered.
- ss  output  1  slave select, high for the whole frame, low when idle; registered.
- busy  output  1  high from the accept edge until the return to IDLE.
- done  output  1  one-clk pulse in the cycle ss falls after a complete frame.

## Operation
- The accept edge loads a 48-bit shift register with {word0, word1, word2}. Later changes on the word inputs have no effect on the frame in flight.
- States and transitions:
  - IDLE to LEAD on accept.
  - LEAD to XFER after CLK_DIV cycles.
  - XFER to GAP after the 48th falling sclk edge plus CLK_DIV low cycles.
  - GAP to IDLE after CLK_DIV cycles.
- LEAD: ss=1, sclk=0, mosi=bit47.
- XFER: 48 sclk periods, each CLK_DIV cycles high followed by CLK_DIV cycles low.
  - At each falling edge the shift register moves left by 1 and mosi takes the next bit.
  - After the 48th falling edge mosi=0.
- Counters:
  - Bit counter is 6 bits and counts falling edges 0..47 (no wrap).
  - Divider counter counts 0..CLK_DIV-1 and reloads at each sclk toggle.
- GAP: ss=0, sclk=0, mosi=0, in_ready=0. done=1 in the first GAP cycle only.
- in_valid while in_ready=0 is ignored. It is not queued, and words are not sampled.
- If in_valid is held high continuously, frames repeat back to back, separated by exactly CLK_DIV ss-low GAP cycles plus one IDLE accept cycle.
- Reset values: sclk=0, mosi=0, ss=0, busy=0, done=0, in_ready=1 (IDLE), shift register=0, counters=0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously). The frame is abandoned, no done is issued, and the block is in IDLE after release.

## Timing
- Accept edge to ss=1: 1 clk cycle. mosi=bit47 in the same cycle.
- ss stays high for exactly 97*CLK_DIV cycles (CLK_DIV LEAD cycles + 96*CLK_DIV XFER cycles).
- First rising sclk edge is CLK_DIV cycles after ss rises. Setup of bit47 is CLK_DIV cycles.
- Each mosi bit is stable for 2*CLK_DIV cycles around its rising edge: CLK_DIV cycles of setup and CLK_DIV cycles of hold.
- After the 48th rising edge: sclk high CLK_DIV cycles, then low CLK_DIV cycles, then ss falls. done pulses in the same cycle.
- in_ready returns high CLK_DIV cycles after ss falls.
- Minimum frame-to-frame period: 98*CLK_DIV + 1 cycles.
- With CLK_DIV=1, sclk toggles every clk cycle and ss is high for 97 cycles.

## Test plan
- Reset check: assert reset for 3 cycles with in_valid=1. Required: sclk=0, ss=0, mosi=0, busy=0, done=0, in_ready=1 throughout, and no frame starts until reset is released.
- Single frame, CLK_DIV=4, words 0x1234/0x8000/0x7FFF. Required:
  - A model receiver sampling on rising sclk while ss=1 captures 0x123480007FFF.
  - Exactly 48 rising edges occur, ss is high for 388 cycles, and done is a single pulse.
  - Receiver sign outputs read word0 positive, word1 negative, word2 positive.
- Back to back, in_valid held high, words 0xAAAA/0x5555/0x0001 then 0xFFFF/0x0000/0x8001. Required: two correct frames with ss low for exactly 4 GAP cycles plus 1 accept cycle between them.
- Busy rejection: pulse in_valid with different words at bits 10 and 40 of a frame. Required: the in-flight frame is unchanged and no extra frame follows.
- Reset mid-frame after 20 rising edges. Required: outputs go to reset values within the same cycle, no done pulse, and a fresh frame afterwards is correct.
- CLK_DIV=1, words 0x0F0F/0xF0F0/0x3C3C. Required: sclk toggles every cycle, ss is high for 97 cycles, and the captured data is 0x0F0FF0F03C3C.
